dmem_responder: RTL and testbench

Word-addressed data memory that answers the load/store requests issued by the multi-cycle CPU's Memory stage (LW/SW). It accepts one request at a time and inserts a programmable number of wait states. It returns a single-cycle acknowledge carrying read data or a misalignment error. It sits between the CPU state machine and the data storage array, so the CPU can leave its Memory stage only on `ack`.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store request/acknowledge bundle between the CPU Memory stage (master)
// and the data memory responder (slave).
interface dmem_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              ack;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  busy, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, ack, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering one LW/SW at a time, with LATENCY
// wait states and a single-cycle ack carrying read data or a misalignment flag.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              busy_q;
    logic              ack_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic              commit;
    logic              misal;
    logic [ADDR_W-3:0] idx;

    // With zero wait states the commit happens on the accept edge itself, so
    // the request must come straight from the bus rather than the latches.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        if (state_q == S_IDLE) begin
            we_d    = bus.we;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
            commit  = (LATENCY == 0) && bus.req;
        end else if (state_q == S_WAIT) begin
            commit  = (cnt_q == 4'd0);
        end
    end

    assign misal = |addr_d[1:0];
    assign idx   = addr_d[ADDR_W-1:2];

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && commit && we_d && !misal) begin
            mem_q[idx] <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ack_q <= 1'b0;
            if (commit) begin
                ack_q   <= 1'b1;
                err_q   <= misal;
                rdata_q <= (we_d || misal) ? 32'h0 : mem_q[idx];
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance
// share clock and reset, each driven through its own interface.
module tb_dmem_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(10)) b0 ();
    dmem_if #(.ADDR_W(10)) b1 ();

    dmem_responder #(.ADDR_W(10), .DEPTH_WORDS(256), .LATENCY(2)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    dmem_responder #(.ADDR_W(10), .DEPTH_WORDS(256), .LATENCY(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [9:0] a, input logic [31:0] d);
        if (sel) begin
            b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d;
        end else begin
            b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
        end
    endtask

    function automatic logic get_ack(input bit sel);
        return sel ? b1.ack : b0.ack;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? b1.busy : b0.busy;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request; after acceptance the bus is scrambled to show inputs are ignored.
    task automatic xact(input bit sel, input logic w, input logic [9:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
        lat = -1;
        rd  = 32'hx;
        er  = 1'bx;
        drive(sel, 1'b1, w, a, d);
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 1) drive(sel, 1'b0, ~w, ~a, ~d);
            if (get_ack(sel)) begin
                lat = n;
                rd  = sel ? b1.rdata : b0.rdata;
                er  = sel ? b1.err : b0.err;
                break;
            end
        end
        step();
        chk("ack_single_cycle", {31'b0, get_ack(sel)}, 32'd0);
        chk("busy_after_ack", {31'b0, get_busy(sel)}, 32'd0);
        drive(sel, 1'b0, 1'b0, 10'h0, 32'h0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [11:0] ackv;
        logic [11:0] busyv;
        logic [5:0]  ackz;
        logic [5:0]  busyz;

        drive(1'b0, 1'b1, 1'b0, 10'h010, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 10'h010, 32'h0);
        repeat (3) step();
        chk("rst_ack", {31'b0, b0.ack}, 32'd0);
        chk("rst_busy", {31'b0, b0.busy}, 32'd0);
        chk("rst_rdata", b0.rdata, 32'h0);
        chk("rst_err", {31'b0, b0.err}, 32'd0);
        chk("rst_busy_l0", {31'b0, b1.busy}, 32'd0);
        chk("rst_ack_l0", {31'b0, b1.ack}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", {31'b0, b0.busy}, 32'd0);

        xact(1'b0, 1'b1, 10'h020, 32'h11112222, lat, rd, er);
        chk("pre_sw_lat", lat, 32'd3);
        chk("pre_sw_err", {31'b0, er}, 32'd0);

        xact(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, lat, rd, er);
        chk("sw_lat", lat, 32'd3);
        chk("sw_err", {31'b0, er}, 32'd0);
        chk("sw_rdata", rd, 32'h0);

        xact(1'b0, 1'b0, 10'h010, 32'h0, lat, rd, er);
        chk("lw_lat", lat, 32'd3);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'b0, er}, 32'd0);

        xact(1'b0, 1'b1, 10'h012, 32'h12345678, lat, rd, er);
        chk("mis_lat", lat, 32'd3);
        chk("mis_err", {31'b0, er}, 32'd1);
        chk("mis_rdata", rd, 32'h0);

        xact(1'b0, 1'b0, 10'h010, 32'h0, lat, rd, er);
        chk("lw_after_mis", rd, 32'hDEADBEEF);
        chk("lw_after_mis_err", {31'b0, er}, 32'd0);

        // Continuous req: accept every 4 cycles, inputs disturbed during WAIT.
        drive(1'b0, 1'b1, 1'b0, 10'h010, 32'h0);
        for (int k = 0; k < 12; k++) begin
            step();
            ackv[k]  = b0.ack;
            busyv[k] = b0.busy;
            if (k == 0) drive(1'b0, 1'b1, 1'b1, 10'h020, 32'hFFFFFFFF);
            if (k == 1) drive(1'b0, 1'b1, 1'b0, 10'h010, 32'h0);
            if (b0.ack) chk("stream_rdata", b0.rdata, 32'hDEADBEEF);
        end
        drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("stream_ack_pattern", {20'b0, ackv}, 32'h444);
        chk("stream_busy_pattern", {20'b0, busyv}, 32'h777);
        step();

        xact(1'b0, 1'b0, 10'h020, 32'h0, lat, rd, er);
        chk("stream_no_store", rd, 32'h11112222);

        // Reset while the store sits in WAIT.
        drive(1'b0, 1'b1, 1'b1, 10'h020, 32'hAAAA5555);
        step();
        drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("mid_busy_before", {31'b0, b0.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy_async", {31'b0, b0.busy}, 32'd0);
        lat = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (b0.ack) lat++;
        end
        chk("mid_no_ack", lat, 32'd0);
        rst_n = 1'b1;
        step();
        xact(1'b0, 1'b0, 10'h020, 32'h0, lat, rd, er);
        chk("mid_lw_lat", lat, 32'd3);
        chk("mid_lw_prior", rd, 32'h11112222);

        // Zero-wait-state instance.
        xact(1'b1, 1'b1, 10'h3FC, 32'h00000001, lat, rd, er);
        chk("l0_sw_lat", lat, 32'd1);
        chk("l0_sw_err", {31'b0, er}, 32'd0);
        xact(1'b1, 1'b0, 10'h3FC, 32'h0, lat, rd, er);
        chk("l0_lw_lat", lat, 32'd1);
        chk("l0_lw_rdata", rd, 32'h00000001);

        drive(1'b1, 1'b1, 1'b0, 10'h3FC, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            ackz[k]  = b1.ack;
            busyz[k] = b1.busy;
            if (b1.ack) chk("l0_stream_rdata", b1.rdata, 32'h00000001);
        end
        drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("l0_ack_pattern", {26'b0, ackz}, 32'h15);
        chk("l0_busy_pattern", {26'b0, busyz}, 32'h15);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
